// File: rtl/move_controller.sv
// Command-execution stage: decodes MOVE/TELEPORT/NOP and walks the player
// one tile per step with bound and wall checks against the map RAM.
module move_controller #(
  parameter int MAP_W     = 10,
  parameter int MAP_H     = 10,
  parameter int START_POS = 50,
  parameter int EXIT_POS  = 59,
  parameter int WALL_CODE = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic [6:0]  map_addr,
  input  logic [15:0] map_data,
  output logic [15:0] pos,
  output logic        step,
  output logic        move_done,
  output logic        blocked,
  output logic        at_exit
);

  localparam logic [15:0] W16   = 16'(MAP_W);
  localparam logic [15:0] LAST  = 16'(MAP_W * (MAP_H - 1));
  localparam logic [15:0] START = 16'(START_POS);
  localparam logic [15:0] EXIT  = 16'(EXIT_POS);
  localparam logic [15:0] WALL  = 16'(WALL_CODE);

  localparam logic [3:0] OP_MOVE = 4'd1;
  localparam logic [3:0] OP_TELE = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_EVAL,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [15:0] pos_q;
  logic [15:0] tgt_q;
  logic [1:0]  dir_q;
  logic [3:0]  rem_q;
  logic [6:0]  addr_q;
  logic        ready_q;
  logic        step_q;
  logic        done_q;
  logic        blk_q;

  logic [15:0] col_d;
  logic [15:0] tgt_d;
  logic        oob_d;

  logic [3:0]  op;
  logic        unused_bits;

  assign op          = cmd_data[15:12];
  assign unused_bits = ^cmd_data[9:4];

  // Bound test precedes any subtract, so the target never wraps.
  always_comb begin
    col_d = pos_q % W16;
    oob_d = 1'b0;
    tgt_d = pos_q;
    unique case (dir_q)
      2'd0: begin
        oob_d = pos_q < W16;
        if (!oob_d) tgt_d = pos_q - W16;
      end
      2'd1: begin
        oob_d = pos_q >= LAST;
        if (!oob_d) tgt_d = pos_q + W16;
      end
      2'd2: begin
        oob_d = col_d == 16'd0;
        if (!oob_d) tgt_d = pos_q - 16'd1;
      end
      default: begin
        oob_d = col_d == (W16 - 16'd1);
        if (!oob_d) tgt_d = pos_q + 16'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pos_q   <= START;
      tgt_q   <= START;
      dir_q   <= 2'd0;
      rem_q   <= 4'd0;
      addr_q  <= 7'd0;
      ready_q <= 1'b1;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      blk_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            ready_q <= 1'b0;
            dir_q   <= cmd_data[11:10];
            rem_q   <= cmd_data[3:0];
            if (op == OP_MOVE && cmd_data[3:0] != 4'd0) begin
              state_q <= S_CHECK;
            end else begin
              if (op == OP_TELE) pos_q <= START;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_CHECK: begin
          if (oob_d) begin
            done_q  <= 1'b1;
            blk_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tgt_q   <= tgt_d;
            addr_q  <= tgt_d[6:0];
            state_q <= S_READ;
          end
        end
        S_READ: state_q <= S_EVAL;
        S_EVAL: begin
          if (map_data == WALL) begin
            done_q  <= 1'b1;
            blk_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            pos_q  <= tgt_q;
            step_q <= 1'b1;
            rem_q  <= rem_q - 4'd1;
            if (tgt_q == EXIT || rem_q == 4'd1) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CHECK;
            end
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign map_addr  = addr_q;
  assign pos       = pos_q;
  assign step      = step_q;
  assign move_done = done_q;
  assign blocked   = blk_q;
  assign at_exit   = pos_q == EXIT;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: directed scenarios plus random commands
// checked cycle by cycle against a row/column walk model.
module tb_move_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = 16'h0;
  logic [6:0]  map_addr;
  logic [15:0] map_data = 16'h0;
  logic [15:0] pos;
  logic        step;
  logic        move_done;
  logic        blocked;
  logic        at_exit;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [128];
  int cur_pos;
  int exp_path[$];
  bit exp_blk;
  int exp_d;

  move_controller dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data),
    .map_addr(map_addr), .map_data(map_data),
    .pos(pos), .step(step),
    .move_done(move_done), .blocked(blocked),
    .at_exit(at_exit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) map_data <= mem[map_addr];

  task automatic model(input logic [15:0] c);
    int p, op, dir, n, r, col, t;
    bit oob;
    op = int'(c[15:12]);
    dir = int'(c[11:10]);
    n = int'(c[3:0]);
    exp_path.delete();
    exp_blk = 0;
    exp_d = 0;
    p = (op == 2) ? 50 : cur_pos;
    exp_path.push_back(p);
    if (op == 1) begin
      for (int k = 0; k < n; k++) begin
        r = p / 10;
        col = p % 10;
        oob = 0;
        t = p;
        case (dir)
          0: begin oob = (r == 0); t = p - 10; end
          1: begin oob = (r == 9); t = p + 10; end
          2: begin oob = (col == 0); t = p - 1; end
          default: begin oob = (col == 9); t = p + 1; end
        endcase
        if (oob) begin
          exp_blk = 1; exp_d = 3 * k + 1; break;
        end
        if (mem[t] == 16'd5) begin
          exp_blk = 1; exp_d = 3 * (k + 1); break;
        end
        p = t;
        exp_path.push_back(p);
        exp_d = 3 * (k + 1);
        if (p == 59) break;
      end
    end
  endtask

  task automatic run_cmd(input logic [15:0] c, input string nm);
    int e, idx, nst, fin;
    bit seen, es;
    model(c);
    fin = exp_path[exp_path.size() - 1];
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_before: got %b exp 1", nm, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_data = c;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data = 16'($urandom);
    e = 0; nst = 0; seen = 0;
    while (!seen && e < 60) begin
      @(negedge clk);
      idx = e / 3;
      if (idx > exp_path.size() - 1) idx = exp_path.size() - 1;
      tests++;
      if (pos !== 16'(exp_path[idx])) begin
        fails++;
        $display("FAIL %s pos@%0d: got %0d exp %0d", nm, e, pos, exp_path[idx]);
      end
      es = (e > 0) && (e % 3 == 0) && (e / 3 <= exp_path.size() - 1);
      tests++;
      if (step !== es) begin
        fails++;
        $display("FAIL %s step@%0d: got %b exp %b", nm, e, step, es);
      end
      if (step === 1'b1) nst++;
      if (move_done === 1'b1) begin
        seen = 1;
        tests++;
        if (e != exp_d) begin
          fails++;
          $display("FAIL %s latency: got %0d exp %0d", nm, e, exp_d);
        end
        tests++;
        if (blocked !== exp_blk) begin
          fails++;
          $display("FAIL %s blocked: got %b exp %b", nm, blocked, exp_blk);
        end
        tests++;
        if (at_exit !== (fin == 59)) begin
          fails++;
          $display("FAIL %s at_exit: got %b exp %b", nm, at_exit, fin == 59);
        end
        tests++;
        if (nst != exp_path.size() - 1) begin
          fails++;
          $display("FAIL %s steps: got %0d exp %0d", nm, nst, exp_path.size() - 1);
        end
      end else begin
        @(posedge clk);
        e++;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s timeout: got no move_done exp done at %0d", nm, exp_d);
    end
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1 || move_done !== 1'b0 || blocked !== 1'b0) begin
      fails++;
      $display("FAIL %s after_done: got rdy=%b done=%b blk=%b exp 1 0 0",
               nm, cmd_ready, move_done, blocked);
    end
    cur_pos = fin;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 128; i++) mem[i] = 16'd4;
    rst_n = 1'b0;
    #12;
    for (int r = 0; r < 2; r++) begin
      tests++;
      if (pos !== 16'd50 || cmd_ready !== 1'b1 || at_exit !== 1'b0) begin
        fails++;
        $display("FAIL reset_state%0d: got pos=%0d rdy=%b exit=%b exp 50 1 0",
                 r, pos, cmd_ready, at_exit);
      end
      tests++;
      if (step !== 1'b0 || move_done !== 1'b0 || blocked !== 1'b0 || map_addr !== 7'd0) begin
        fails++;
        $display("FAIL reset_pulses%0d: got %b%b%b addr=%0d exp 000 0",
                 r, step, move_done, blocked, map_addr);
      end
      if (r == 0) begin
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
      end
    end
    cur_pos = 50;
  endtask

  task automatic test_free_move;
    for (int i = 0; i < 128; i++) mem[i] = 16'd4;
    run_cmd(16'h1C03, "free_right3");
  endtask

  task automatic test_bound;
    logic [6:0] a0;
    run_cmd(16'h2000, "tele_bound");
    a0 = map_addr;
    run_cmd(16'h1801, "bound_left1");
    tests++;
    if (map_addr !== a0) begin
      fails++;
      $display("FAIL bound_noread: got addr=%0d exp %0d", map_addr, a0);
    end
  endtask

  task automatic test_wall;
    run_cmd(16'h2000, "tele_wall");
    mem[52] = 16'd5;
    run_cmd(16'h1C04, "wall_right4");
    mem[52] = 16'd4;
  endtask

  task automatic test_exit;
    run_cmd(16'h2000, "tele_exit");
    run_cmd(16'h1C07, "right7");
    run_cmd(16'h1C05, "exit_right5");
  endtask

  task automatic test_random;
    logic [15:0] c;
    int r;
    for (int i = 0; i < 100; i++)
      mem[i] = ($urandom_range(0, 4) == 0) ? 16'd5 : 16'($urandom_range(0, 4));
    for (int i = 0; i < 40; i++) begin
      c = 16'($urandom);
      r = $urandom_range(0, 15);
      if (r < 10) c[15:12] = 4'd1;
      else if (r < 12) c[15:12] = 4'd2;
      run_cmd(c, $sformatf("rand%0d", i));
    end
    for (int i = 0; i < 128; i++) mem[i] = 16'd4;
  endtask

  task automatic test_reset_mid;
    int e;
    int busy_bad;
    run_cmd(16'h2000, "tele_mid");
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data = 16'h1C03;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    tests++;
    if (pos !== 16'd51) begin
      fails++;
      $display("FAIL mid_pre: got pos=%0d exp 51", pos);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (pos !== 16'd50 || cmd_ready !== 1'b1 || step !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got pos=%0d rdy=%b step=%b exp 50 1 0", pos, cmd_ready, step);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cur_pos = 50;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data = 16'h1C02;
    @(posedge clk);
    #1 cmd_data = 16'h1802;
    e = 0;
    busy_bad = 0;
    while (e < 30) begin
      @(negedge clk);
      if (move_done === 1'b1) break;
      if (cmd_ready !== 1'b0) busy_bad++;
      @(posedge clk);
      e++;
    end
    cmd_valid = 1'b0;
    tests++;
    if (move_done !== 1'b1 || pos !== 16'd52 || blocked !== 1'b0) begin
      fails++;
      $display("FAIL hold_valid: got done=%b pos=%0d blk=%b exp 1 52 0", move_done, pos, blocked);
    end
    tests++;
    if (busy_bad != 0) begin
      fails++;
      $display("FAIL busy_ready: got %0d ready cycles exp 0", busy_bad);
    end
    cur_pos = 52;
    run_cmd(16'h0000, "nop_after");
  endtask

  initial begin
    test_reset();
    test_free_move();
    test_bound();
    test_wall();
    test_exit();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
